// File: rtl/ram_burst_port_ctrl.sv
// Burst initiator for a single-port sync RAM: host command plus valid/ready
// write stream in, valid/ready read stream out through a 2-entry FIFO.
module ram_burst_port_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  // Counters hold a word count (len+1) so a full 2**ADDR_WIDTH burst fits.
  logic [ADDR_WIDTH:0]   iss_q, iss_d, left_q, left_d;
  logic                  infl_q, infl_d;
  logic [1:0][DATA_WIDTH-1:0] fifo_q, fifo_d;
  logic                  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic       cmd_hs, wr_hs, pop, issue;
  logic [2:0] occ;

  assign cmd_hs = cmd_valid && (state_q == S_IDLE);
  assign wr_hs  = wr_valid && (state_q == S_WRITE);
  assign pop    = (cnt_q != 2'd0) && rd_ready;
  assign occ    = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  // Throttle so queued plus in-flight words never exceed the FIFO depth.
  assign issue  = (state_q == S_READ) && (iss_q != '0) && (occ < 3'd2);

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign wr_ready  = (state_q == S_WRITE);
  assign ram_we    = wr_hs;
  assign ram_addr  = (wr_hs || issue) ? addr_q : raddr_q;
  assign ram_din   = wr_hs ? wr_data : din_q;
  assign rd_valid  = (cnt_q != 2'd0);
  assign rd_data   = fifo_q[rptr_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    left_d  = left_q;
    raddr_d = ram_addr;
    din_d   = ram_din;
    infl_d  = issue;
    fifo_d  = fifo_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (cmd_hs) begin
        addr_d  = cmd_addr;
        iss_d   = {1'b0, cmd_len} + CNT_ONE;
        left_d  = {1'b0, cmd_len} + CNT_ONE;
        state_d = cmd_write ? S_WRITE : S_READ;
      end
      S_WRITE: if (wr_hs) begin
        addr_d = addr_q + ADDR_ONE;
        left_d = left_q - CNT_ONE;
        if (left_q == CNT_ONE) state_d = S_IDLE;
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + ADDR_ONE;
          iss_d  = iss_q - CNT_ONE;
        end
        if (pop) begin
          left_d = left_q - CNT_ONE;
          if (left_q == CNT_ONE) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // RAM data for last cycle's issue is on ram_dout now.
    if (infl_q) begin
      fifo_d[wptr_q] = ram_dout;
      wptr_d = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
    cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      iss_q   <= '0;
      left_q  <= '0;
      raddr_q <= '0;
      din_q   <= '0;
      infl_q  <= 1'b0;
      fifo_q  <= '0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      left_q  <= left_d;
      raddr_q <= raddr_d;
      din_q   <= din_d;
      infl_q  <= infl_d;
      fifo_q  <= fifo_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_port_ctrl.sv
// Randomized bench for ram_burst_port_ctrl: behavioural RAM plus a shadow
// memory model; bursts checked word-by-word and against protocol timing.
module tb_ram_burst_port_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready, busy;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] wq [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_burst_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous RAM: registered address, data one cycle later.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] len,
                          input int gap0, input int gapprob);
    int k = 0;
    int c = 1;
    logic v;
    logic [AW-1:0] ea;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len; wr_valid = 1'b0;
    @(negedge clk);
    chk("w_cmd_ready_c0", cmd_ready, 1);
    chk("w_wr_ready_c0", wr_ready, 0);
    next_cyc();
    while (k <= int'(len) && c < 20000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      v = (c > gap0) && (int'($urandom_range(0, 99)) >= gapprob);
      wr_valid = v;
      wr_data  = v ? wq[k] : DW'($urandom);
      @(negedge clk);
      chk("w_cmd_ready_busy", cmd_ready, 0);
      chk("w_busy", busy, 1);
      chk("w_wr_ready", wr_ready, 1);
      chk("w_ram_we", ram_we, v);
      if (v) begin
        ea = a + AW'(k);
        chk("w_ram_addr", ram_addr, ea);
        chk("w_ram_din", ram_din, wq[k]);
        shadow[ea] = wq[k];
        k++;
      end
      next_cyc();
      c++;
    end
    if (k <= int'(len)) chk("w_budget", 0, 1);
    cmd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("w_done_cmd_ready", cmd_ready, 1);
    chk("w_done_busy", busy, 0);
    chk("w_done_wr_ready", wr_ready, 0);
    chk("w_done_ram_we", ram_we, 0);
    next_cyc();
  endtask

  // mode 0: rd_ready always 1; 1: fixed toggle pattern; 2: random.
  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] len, input int mode);
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int k = 0;
    int c = 1;
    int last_c = 0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [AW-1:0] ea;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len; rd_ready = 1'b0;
    @(negedge clk);
    chk("r_cmd_ready_c0", cmd_ready, 1);
    chk("r_rd_valid_c0", rd_valid, 0);
    next_cyc();
    while (k <= int'(len) && c < 20000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = (c - 1 < 7) ? 1'(pat[c-1]) : 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("r_ram_we", ram_we, 0);
      chk("r_cmd_ready_busy", cmd_ready, 0);
      if (c == 1) chk("r_first_addr", ram_addr, a);
      if (mode == 0) chk("r_valid_timing", rd_valid, (c >= 3) ? 1 : 0);
      if (stalled) begin
        chk("r_hold_valid", rd_valid, 1);
        chk("r_hold_data", rd_data, held);
      end
      if (rd_valid && rd_ready) begin
        ea = a + AW'(k);
        chk("r_data", rd_data, shadow[ea]);
        k++;
        stalled = 1'b0;
        last_c = c;
      end else if (rd_valid) begin
        stalled = 1'b1;
        held = rd_data;
      end else begin
        stalled = 1'b0;
      end
      next_cyc();
      c++;
    end
    if (k <= int'(len)) chk("r_budget", 0, 1);
    if (mode == 0) chk("r_last_cycle", last_c, 3 + int'(len));
    cmd_valid = 1'b0; rd_ready = 1'b1;
    @(negedge clk);
    chk("r_done_cmd_ready", cmd_ready, 1);
    chk("r_done_busy", busy, 0);
    chk("r_done_rd_valid", rd_valid, 0);
    next_cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
  endtask

  initial begin
    logic [AW-1:0] ra, rl;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    next_cyc();

    // Basic write then readback, full rate.
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(12'h010, 12'd3, 0, 0);
    do_read(12'h010, 12'd3, 0);
    do_read(12'h010, 12'd3, 1);

    // Reset mid-read while stalled.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010; cmd_len = 12'd3; rd_ready = 1'b0;
    next_cyc();
    cmd_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mr_ram_we", ram_we, 0);
      next_cyc();
    end
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mr_in_rst_ram_we", ram_we, 0);
      next_cyc();
    end
    @(negedge clk);
    check_reset_vals("mr_rst");
    reset_n = 1'b1;
    next_cyc();
    repeat (3) begin
      @(negedge clk);
      chk("mr_post_rd_valid", rd_valid, 0);
      chk("mr_post_busy", busy, 0);
      chk("mr_post_cmd_ready", cmd_ready, 1);
      chk("mr_post_ram_we", ram_we, 0);
      next_cyc();
    end
    do_read(12'h010, 12'd3, 0);

    // Address wrap.
    wq = '{8'h11, 8'h12, 8'h13, 8'h14};
    do_write(12'hFFE, 12'd3, 0, 0);
    do_read(12'hFFE, 12'd3, 0);

    // Single word with delayed write data.
    wq = '{8'h5A};
    do_write(12'h200, 12'd0, 3, 0);
    do_read(12'h200, 12'd0, 0);

    // Random bursts with gaps and backpressure.
    for (int it = 0; it < 15; it++) begin
      ra = AW'($urandom);
      rl = AW'($urandom_range(0, 15));
      wq.delete();
      for (int i = 0; i <= int'(rl); i++) wq.push_back(DW'($urandom));
      do_write(ra, rl, int'($urandom_range(0, 2)), 30);
      do_read(ra, rl, 2);
      do_read(ra, rl, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
